// File: rtl/pmc_pkg.sv
// Shared types and defaults for the serial pattern-match controller.
// Holds the controller state encoding and default widths.
package pmc_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pmc_window.sv
// Match window: shift register, fill counter and masked pattern compare.
// Ports: clear/accept/bit_in from control, len/pattern/overlap cfg, hit out.
module pmc_window
  import pmc_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accept,
  input  logic             bit_in,
  input  logic             overlap,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  logic [PAT_W-1:0] window_q, window_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] win_shift;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_inc;
  logic             full;

  always_comb begin
    win_shift = {window_q[PAT_W-2:0], bit_in};
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    fill_inc = fill_q + 1'b1;
    full = (fill_inc >= len);
    hit = accept && full &&
          ((win_shift & mask) == (pattern & mask));
    window_d = window_q;
    fill_d = fill_q;
    if (clear) begin
      window_d = '0;
      fill_d = '0;
    end else if (accept) begin
      window_d = win_shift;
      fill_d = full ? len : fill_inc;
      // Non-overlap: the matched bits must be refilled before the next hit.
      if (hit && !overlap) begin
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
      fill_q <= '0;
    end else begin
      window_q <= window_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Serial bit-pattern detection controller: FSM, cfg regs, match counter.
// Ports: cfg_* config, start/stop, bit_valid/bit_in/bit_ready, match/cnt/busy/done.
module pattern_match_ctrl
  import pmc_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W):0]     cfg_len,
  input  logic                       cfg_overlap,
  input  logic [CNT_W-1:0]           cfg_target,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       bit_valid,
  input  logic                       bit_in,
  output logic                       bit_ready,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = $clog2(PAT_W) + 1;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             done_q, done_d;

  logic             accept;
  logic             hit;
  logic             last;
  logic             cfg_ok;
  logic [LEN_W-1:0] len_c;
  logic [CNT_W:0]   cnt_inc;

  pmc_window #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == LOAD),
    .accept  (accept),
    .bit_in  (bit_in),
    .overlap (ovl_q),
    .len     (len_q),
    .pattern (pat_q),
    .hit     (hit)
  );

  always_comb begin
    bit_ready = (state_q == RUN) && !stop;
    accept = bit_valid && bit_ready;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    // Compare in CNT_W+1 bits so a saturated count never re-hits target.
    last = hit && (tgt_q != '0) && (cnt_inc == {1'b0, tgt_q});
    cfg_ok = cfg_we && ((state_q == IDLE) || (state_q == DONE));

    if (cfg_len == '0) begin
      len_c = LEN_W'(1);
    end else if (cfg_len > LEN_W'(PAT_W)) begin
      len_c = LEN_W'(PAT_W);
    end else begin
      len_c = cfg_len;
    end

    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    tgt_d = tgt_q;
    if (cfg_ok) begin
      pat_d = cfg_pattern;
      len_d = len_c;
      ovl_d = cfg_overlap;
      tgt_d = cfg_target;
    end

    state_d = state_q;
    unique case (state_q)
      IDLE: if (!stop && start) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: begin
        if (stop) state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: begin
        if (stop) state_d = IDLE;
        else if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_q == LOAD) begin
      cnt_d = '0;
    end else if (hit && !(&cnt_q)) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end

    match_d = hit;
    done_d = (state_q == RUN) && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q <= '0;
      len_q <= LEN_W'(1);
      ovl_q <= 1'b0;
      tgt_q <= '0;
      cnt_q <= '0;
      match_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      match_q <= match_d;
      done_q <= done_d;
    end
  end

  assign match = match_q;
  assign match_cnt = cnt_q;
  assign done = done_q;
  assign busy = (state_q == LOAD) || (state_q == RUN);

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Directed bench for pattern_match_ctrl, table vectors plus hand sequences.
// A second instance with a 2-bit counter covers saturation.
module tb_pattern_match_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start;
  logic       stop;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready, match, busy, done;
  logic [7:0] match_cnt;
  logic       bit_ready2, match2, busy2, done2;
  logic [1:0] match_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  pattern_match_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .stop(stop), .bit_valid(bit_valid),
    .bit_in(bit_in), .bit_ready(bit_ready), .match(match),
    .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  pattern_match_ctrl #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target[1:0]),
    .start(start), .stop(stop), .bit_valid(bit_valid),
    .bit_in(bit_in), .bit_ready(bit_ready2), .match(match2),
    .match_cnt(match_cnt2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       we;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic [7:0] tgt;
    logic       start;
    logic       stop;
    logic       valid;
    logic       bin;
    logic       r;
    logic       m;
    logic [7:0] c;
    logic       b;
    logic       d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic we, logic [7:0] pat, logic [3:0] len, logic ovl,
    logic [7:0] tgt, logic st, logic sp, logic valid, logic bin,
    logic r, logic m, logic [7:0] c, logic b, logic d);
    vec_t v;
    v.we = we; v.pat = pat; v.len = len; v.ovl = ovl;
    v.tgt = tgt; v.start = st; v.stop = sp;
    v.valid = valid; v.bin = bin;
    v.r = r; v.m = m; v.c = c; v.b = b; v.d = d;
    return v;
  endfunction

  // cfg write while idle
  function automatic void cf(logic [7:0] pat, logic [3:0] len,
                             logic ovl, logic [7:0] tgt,
                             logic [7:0] c);
    tbl.push_back(mk(1, pat, len, ovl, tgt, 0, 0, 0, 0,
                     0, 0, c, 0, 0));
  endfunction

  // start from IDLE/DONE: lands in LOAD, count not yet cleared
  function automatic void st(logic [7:0] c);
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, c, 1, 0));
  endfunction

  // the LOAD cycle: clears count, not ready
  function automatic void ld();
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
  endfunction

  // one accepted bit in RUN
  function automatic void bt(logic bin, logic m, logic [7:0] c);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, bin, 1, m, c, 1, 0));
  endfunction

  // stop with a valid bit presented: bit must not be taken
  function automatic void sp(logic [7:0] c);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, c, 0, 0));
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    cfg_we = v.we;
    cfg_pattern = v.pat;
    cfg_len = v.len;
    cfg_overlap = v.ovl;
    cfg_target = v.tgt;
    start = v.start;
    stop = v.stop;
    bit_valid = v.valid;
    bit_in = v.bin;
  endtask

  task automatic run_vec(vec_t v, int idx);
    drive(v);
    #1;
    chk("bit_ready", idx, 32'(bit_ready), 32'(v.r));
    @(posedge clk);
    #1;
    chk("match", idx, 32'(match), 32'(v.m));
    chk("match_cnt", idx, 32'(match_cnt), 32'(v.c));
    chk("busy", idx, 32'(busy), 32'(v.b));
    chk("done", idx, 32'(done), 32'(v.d));
  endtask

  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #12;
    chk("rst_cnt", -1, 32'(match_cnt), 0);
    chk("rst_match", -1, 32'(match), 0);
    chk("rst_busy", -1, 32'(busy), 0);
    chk("rst_done", -1, 32'(done), 0);
    chk("rst_ready", -1, 32'(bit_ready), 0);
    chk("rst_cnt2", -1, 32'(match_cnt2), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 110 len3, no overlap, unlimited: hits at bits 3,7,11,14
    cf(8'b110, 4'd3, 0, 8'd0, 0); st(0); ld();
    bt(1, 0, 0); bt(1, 0, 0); bt(0, 1, 1);
    bt(1, 0, 1); bt(1, 0, 1); bt(1, 0, 1); bt(0, 1, 2);
    bt(1, 0, 2); bt(1, 0, 2); bt(1, 0, 2); bt(0, 1, 3);
    bt(1, 0, 3); bt(1, 0, 3); bt(0, 1, 4);
    bt(1, 0, 4); bt(1, 0, 4); bt(1, 0, 4);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 1, 0));
    sp(4);

    // 11 len2 overlap on 1111 -> 3
    cf(8'b11, 4'd2, 1, 8'd0, 4); st(4); ld();
    bt(1, 0, 0); bt(1, 1, 1); bt(1, 1, 2); bt(1, 1, 3);
    sp(3);

    // 11 len2 non-overlap on 1111 -> 2
    cf(8'b11, 4'd2, 0, 8'd0, 3); st(3); ld();
    bt(1, 0, 0); bt(1, 1, 1); bt(1, 0, 1); bt(1, 1, 2);
    sp(2);

    // 110 target 2: DONE after 6th bit, 7th bit stalls
    cf(8'b110, 4'd3, 0, 8'd2, 2); st(2); ld();
    bt(1, 0, 0); bt(1, 0, 0); bt(0, 1, 1);
    bt(1, 0, 1); bt(1, 0, 1);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0));
    st(2); ld();
    sp(0);

    // cfg write during RUN ignored; stop keeps count
    cf(8'b110, 4'd3, 0, 8'd0, 0); st(0); ld();
    bt(1, 0, 0); bt(1, 0, 0); bt(0, 1, 1); bt(1, 0, 1);
    tbl.push_back(mk(1, 8'b011, 4'd2, 1, 8'd1, 0, 0, 0, 0,
                     1, 0, 1, 1, 0));
    sp(1);
    st(1); ld();
    bt(0, 0, 0); bt(1, 0, 0); bt(1, 0, 0); bt(0, 1, 1);
    bt(1, 0, 1);
    sp(1);

    // len 0 acts as len 1
    cf(8'h01, 4'd0, 1, 8'd0, 1); st(1); ld();
    bt(1, 1, 1); bt(0, 0, 1); bt(1, 1, 2);
    sp(2);

    // len 15 clamps to 8
    cf(8'h81, 4'd15, 0, 8'd0, 2); st(2); ld();
    bt(1, 0, 0);
    for (int k = 0; k < 6; k++) bt(0, 0, 0);
    bt(1, 1, 1);
    sp(1);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // counter saturation on the 2-bit instance
    tbl.delete();
    cf(8'h01, 4'd1, 0, 8'd0, 1); st(1); ld();
    foreach (tbl[i]) run_vec(tbl[i], 100 + i);
    for (int k = 1; k <= 6; k++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      chk("sat_match", k, 32'(match), 1);
      chk("sat_cnt", k, 32'(match_cnt), 32'(k));
      chk("sat_match2", k, 32'(match2), 1);
      chk("sat_cnt2", k, 32'(match_cnt2), (k > 3) ? 3 : k);
    end
    tbl.delete();
    sp(6);
    foreach (tbl[i]) run_vec(tbl[i], 200 + i);

    // async reset mid-run with a partial window
    tbl.delete();
    cf(8'b110, 4'd3, 0, 8'd0, 6); st(6); ld();
    bt(1, 0, 0); bt(1, 0, 0); bt(0, 1, 1); bt(1, 0, 1); bt(1, 0, 1);
    foreach (tbl[i]) run_vec(tbl[i], 300 + i);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", -2, 32'(match_cnt), 0);
    chk("ar_match", -2, 32'(match), 0);
    chk("ar_busy", -2, 32'(busy), 0);
    chk("ar_done", -2, 32'(done), 0);
    chk("ar_ready", -2, 32'(bit_ready), 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_pulse", -3, 32'(match | done), 0);

    // cfg back to pattern 0 len 1, then 110 matches exactly once
    tbl.delete();
    st(0); ld();
    bt(0, 1, 1);
    sp(1);
    cf(8'b110, 4'd3, 0, 8'd0, 1); st(1); ld();
    bt(1, 0, 0); bt(1, 0, 0); bt(0, 1, 1);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    sp(1);
    foreach (tbl[i]) run_vec(tbl[i], 400 + i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
